// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_pipe
// Description : Registered instruction-decode stage with valid/ready on both
//               sides, branch resolution and sticky halt. Optional macro
//               ID_HAZARD_STALL_EN adds a two-deep read-after-write stall.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4,
    parameter int BOFF_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] pc,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic              flag_v,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RA_W-1:0]   p0_addr,
    output logic [RA_W-1:0]   p1_addr,
    output logic [RA_W-1:0]   dst_addr,
    output logic              re0,
    output logic              re1,
    output logic              we,
    output logic [RA_W-1:0]   shamt,
    output logic [2:0]        func,
    output logic              src1sel,
    output logic              redirect,
    output logic [DATA_W-1:0] new_pc,
    output logic              hlt
);

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_ADDZ = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_AND  = 4'h3;
    localparam logic [3:0] c_OP_NOR  = 4'h4;
    localparam logic [3:0] c_OP_SLL  = 4'h5;
    localparam logic [3:0] c_OP_SRL  = 4'h6;
    localparam logic [3:0] c_OP_SRA  = 4'h7;
    localparam logic [3:0] c_OP_LHB  = 4'hA;
    localparam logic [3:0] c_OP_LLB  = 4'hB;
    localparam logic [3:0] c_OP_B    = 4'hC;
    localparam logic [3:0] c_OP_JAL  = 4'hD;
    localparam logic [3:0] c_OP_JR   = 4'hE;
    localparam logic [3:0] c_OP_HLT  = 4'hF;

    // ------------------------------------------------------------------------
    // Combinational decode of the candidate instruction
    // ------------------------------------------------------------------------
    logic [3:0]        w_op;
    logic [2:0]        w_cond;
    logic [RA_W-1:0]   w_dst;
    logic [RA_W-1:0]   w_p1;
    logic [RA_W-1:0]   w_p0;
    logic [RA_W-1:0]   w_shamt;
    logic [2:0]        w_func;
    logic              w_we;
    logic              w_re;
    logic              w_src1sel;
    logic              w_is_br;
    logic              w_is_hlt;
    logic              w_cond_met;
    logic              w_taken;
    logic [DATA_W-1:0] w_boff_sext;
    logic [DATA_W-1:0] w_pc_inc;
    logic [DATA_W-1:0] w_next_pc;
    logic              w_accept;
    logic              w_hazard;

    assign w_op    = instr[DATA_W-1 -: 4];
    assign w_cond  = instr[BOFF_W +: 3];
    assign w_dst   = instr[2*RA_W +: RA_W];
    assign w_p1    = instr[RA_W +: RA_W];
    assign w_p0    = (w_op == c_OP_LHB) ? instr[2*RA_W +: RA_W] : instr[0 +: RA_W];
    assign w_shamt = (w_op == c_OP_LLB) ? '0 : instr[0 +: RA_W];

    always_comb begin
        w_func    = 3'b000;
        w_we      = 1'b1;
        w_re      = 1'b1;
        w_src1sel = 1'b1;
        w_is_br   = 1'b0;
        w_is_hlt  = 1'b0;
        case (w_op)
            c_OP_ADD, c_OP_JAL: w_func = 3'b000;
            c_OP_ADDZ:          w_we   = flag_z;
            c_OP_SUB:           w_func = 3'b001;
            c_OP_AND:           w_func = 3'b010;
            c_OP_NOR:           w_func = 3'b011;
            c_OP_SLL:           w_func = 3'b100;
            c_OP_SRL:           w_func = 3'b101;
            c_OP_SRA:           w_func = 3'b111;
            c_OP_LHB: begin
                w_func    = 3'b110;
                w_src1sel = 1'b0;
            end
            c_OP_LLB: begin
                w_func    = 3'b100;
                w_src1sel = 1'b0;
                w_re      = 1'b0;
            end
            c_OP_B: begin
                w_we    = 1'b0;
                w_re    = 1'b0;
                w_is_br = 1'b1;
            end
            c_OP_JR:            w_we = 1'b0;
            c_OP_HLT: begin
                w_we     = 1'b0;
                w_is_hlt = 1'b1;
            end
            default:            w_we = 1'b0;
        endcase
    end

    always_comb begin
        w_cond_met = 1'b0;
        case (w_cond)
            3'b000:  w_cond_met = !flag_z;
            3'b001:  w_cond_met = flag_z;
            3'b010:  w_cond_met = !flag_z && !flag_n;
            3'b011:  w_cond_met = flag_n;
            3'b100:  w_cond_met = !flag_n;
            3'b101:  w_cond_met = flag_n || flag_z;
            3'b110:  w_cond_met = flag_v;
            default: w_cond_met = 1'b1;
        endcase
    end

    assign w_taken     = w_is_br && w_cond_met;
    assign w_boff_sext = {{(DATA_W-BOFF_W){instr[BOFF_W-1]}}, instr[BOFF_W-1:0]};
    assign w_pc_inc    = pc + DATA_W'(1);
    assign w_next_pc   = w_taken ? (w_pc_inc + w_boff_sext) : w_pc_inc;

    // ------------------------------------------------------------------------
    // Output register bank
    // ------------------------------------------------------------------------
    logic              r_out_valid;
    logic              r_hlt;
    logic              r_redirect;
    logic [DATA_W-1:0] r_new_pc;
    logic [RA_W-1:0]   r_p0;
    logic [RA_W-1:0]   r_p1;
    logic [RA_W-1:0]   r_dst;
    logic [RA_W-1:0]   r_shamt;
    logic [2:0]        r_func;
    logic              r_re0;
    logic              r_re1;
    logic              r_we;
    logic              r_src1sel;

    assign in_ready = !r_hlt && (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_hlt       <= 1'b0;
            r_redirect  <= 1'b0;
            r_new_pc    <= '0;
            r_p0        <= '0;
            r_p1        <= '0;
            r_dst       <= '0;
            r_shamt     <= '0;
            r_func      <= 3'b000;
            r_re0       <= 1'b0;
            r_re1       <= 1'b0;
            r_we        <= 1'b0;
            r_src1sel   <= 1'b0;
        end else begin
            // redirect only lives for the first valid cycle of its bundle
            r_redirect <= 1'b0;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_redirect  <= w_taken;
                r_new_pc    <= w_next_pc;
                r_p0        <= w_p0;
                r_p1        <= w_p1;
                r_dst       <= w_dst;
                r_shamt     <= w_shamt;
                r_func      <= w_func;
                r_re0       <= w_re;
                r_re1       <= w_re;
                r_we        <= w_we;
                r_src1sel   <= w_src1sel;
                if (w_is_hlt) begin
                    r_hlt <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef ID_HAZARD_STALL_EN
    // Two-entry history of emitted writers; entry 0 is the youngest.
    logic [RA_W-1:0] r_hz0_dst;
    logic            r_hz0_we;
    logic [RA_W-1:0] r_hz1_dst;
    logic            r_hz1_we;
    logic            w_hit_p0;
    logic            w_hit_p1;

    assign w_hit_p0 = (w_p0 != '0) &&
                      ((r_hz0_we && (w_p0 == r_hz0_dst)) || (r_hz1_we && (w_p0 == r_hz1_dst)));
    assign w_hit_p1 = (w_p1 != '0) &&
                      ((r_hz0_we && (w_p1 == r_hz0_dst)) || (r_hz1_we && (w_p1 == r_hz1_dst)));
    assign w_hazard = w_re && (w_hit_p0 || w_hit_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hz0_dst <= '0;
            r_hz0_we  <= 1'b0;
            r_hz1_dst <= '0;
            r_hz1_we  <= 1'b0;
        end else if (!(r_out_valid && !out_ready)) begin
            // handshakes and bubbles both age the history; a held bundle does not
            r_hz0_dst <= w_dst;
            r_hz0_we  <= w_accept && w_we;
            r_hz1_dst <= r_hz0_dst;
            r_hz1_we  <= r_hz0_we;
        end
    end
`else
    assign w_hazard = 1'b0;
`endif

    assign out_valid = r_out_valid;
    assign hlt       = r_hlt;
    assign redirect  = r_redirect;
    assign new_pc    = r_new_pc;
    assign p0_addr   = r_p0;
    assign p1_addr   = r_p1;
    assign dst_addr  = r_dst;
    assign shamt     = r_shamt;
    assign func      = r_func;
    assign re0       = r_re0;
    assign re1       = r_re1;
    assign we        = r_we;
    assign src1sel   = r_src1sel;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage_pipe
// Description : Directed bench for id_stage_pipe with a per-cycle reference
//               model and literal checkpoints. Honours ID_HAZARD_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  p0_addr;
    logic [3:0]  p1_addr;
    logic [3:0]  dst_addr;
    logic        re0;
    logic        re1;
    logic        we;
    logic [3:0]  shamt;
    logic [2:0]  func;
    logic        src1sel;
    logic        redirect;
    logic [15:0] new_pc;
    logic        hlt;

    int n_tests = 0;
    int n_fail  = 0;

    id_stage_pipe #(.DATA_W(16), .RA_W(4), .BOFF_W(9)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .dst_addr(dst_addr),
        .re0(re0), .re1(re1), .we(we), .shamt(shamt), .func(func),
        .src1sel(src1sel), .redirect(redirect), .new_pc(new_pc), .hlt(hlt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]  p0;
        logic [3:0]  p1;
        logic [3:0]  dst;
        logic        re0;
        logic        re1;
        logic        we;
        logic [3:0]  shamt;
        logic [2:0]  func;
        logic        src1sel;
        logic        taken;
        logic [15:0] npc;
    } exp_t;

    typedef struct packed {
        logic [3:0] dst;
        logic       we;
    } hist_t;

    function automatic exp_t model_decode(input logic [15:0] ins, input logic [15:0] p,
                                          input logic n, input logic z, input logic v);
        exp_t        e;
        logic [3:0]  op;
        logic [2:0]  cond;
        logic [15:0] off;
        logic        ok;
        op   = ins[15:12];
        cond = ins[11:9];
        off  = {{7{ins[8]}}, ins[8:0]};
        e.dst     = ins[11:8];
        e.p1      = ins[7:4];
        e.p0      = (op == 4'hA) ? ins[11:8] : ins[3:0];
        e.shamt   = (op == 4'hB) ? 4'h0 : ins[3:0];
        e.re0     = !(op == 4'hB || op == 4'hC);
        e.re1     = e.re0;
        e.src1sel = !(op == 4'hA || op == 4'hB);
        case (op)
            4'h2:       e.func = 3'd1;
            4'h3:       e.func = 3'd2;
            4'h4:       e.func = 3'd3;
            4'h5, 4'hB: e.func = 3'd4;
            4'h6:       e.func = 3'd5;
            4'hA:       e.func = 3'd6;
            4'h7:       e.func = 3'd7;
            default:    e.func = 3'd0;
        endcase
        case (op)
            4'h8, 4'h9, 4'hC, 4'hE, 4'hF: e.we = 1'b0;
            4'h1:                         e.we = z;
            default:                      e.we = 1'b1;
        endcase
        case (cond)
            3'd0:    ok = !z;
            3'd1:    ok = z;
            3'd2:    ok = !z && !n;
            3'd3:    ok = n;
            3'd4:    ok = !n;
            3'd5:    ok = n || z;
            3'd6:    ok = v;
            default: ok = 1'b1;
        endcase
        e.taken = (op == 4'hC) && ok;
        e.npc   = e.taken ? (p + 16'd1 + off) : (p + 16'd1);
        return e;
    endfunction

    logic  m_init = 1'b0;
    logic  m_valid;
    logic  m_hlt;
    logic  m_redirect;
    exp_t  m_exp;
    hist_t m_hist[$];

    function automatic logic model_stall();
        exp_t c;
        logic s;
        s = 1'b0;
`ifdef ID_HAZARD_STALL_EN
        c = model_decode(instr, pc, flag_n, flag_z, flag_v);
        foreach (m_hist[i]) begin
            if (m_hist[i].we && c.re0 && m_hist[i].dst != 4'h0 &&
                (m_hist[i].dst == c.p0 || m_hist[i].dst == c.p1))
                s = 1'b1;
        end
`endif
        return s;
    endfunction

    function automatic logic model_in_ready();
        return !m_hlt && (!m_valid || out_ready) && !model_stall();
    endfunction

    always @(posedge clk) begin
        logic  acc;
        logic  hold;
        exp_t  e;
        hist_t h;
        if (rst) begin
            m_init     = 1'b1;
            m_valid    = 1'b0;
            m_hlt      = 1'b0;
            m_redirect = 1'b0;
            m_exp      = '0;
            m_hist     = {};
        end else if (m_init) begin
            acc  = in_valid && model_in_ready();
            hold = m_valid && !out_ready;
            e    = model_decode(instr, pc, flag_n, flag_z, flag_v);
            m_redirect = 1'b0;
            if (acc) begin
                m_exp      = e;
                m_valid    = 1'b1;
                m_redirect = e.taken;
                if (instr[15:12] == 4'hF) m_hlt = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (!hold) begin
                h.dst = e.dst;
                h.we  = acc && e.we;
                m_hist.push_front(h);
                while (m_hist.size() > 2) void'(m_hist.pop_back());
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("hlt",       32'(hlt),       32'(m_hlt));
            chk("redirect",  32'(redirect),  32'(m_redirect));
            chk("in_ready",  32'(in_ready),  32'(model_in_ready()));
            if (m_valid) begin
                chk("p0_addr",  32'(p0_addr),  32'(m_exp.p0));
                chk("p1_addr",  32'(p1_addr),  32'(m_exp.p1));
                chk("dst_addr", 32'(dst_addr), 32'(m_exp.dst));
                chk("re0",      32'(re0),      32'(m_exp.re0));
                chk("re1",      32'(re1),      32'(m_exp.re1));
                chk("we",       32'(we),       32'(m_exp.we));
                chk("shamt",    32'(shamt),    32'(m_exp.shamt));
                chk("func",     32'(func),     32'(m_exp.func));
                chk("src1sel",  32'(src1sel),  32'(m_exp.src1sel));
                chk("new_pc",   32'(new_pc),   32'(m_exp.npc));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] p);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (in_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #2;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0;
        flag_n = 1'b0; flag_z = 1'b0; flag_v = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_hlt",       32'(hlt),       32'd0);
        chk("rst_new_pc",    32'(new_pc),    32'd0);
        chk("rst_we",        32'(we),        32'd0);
        chk("rst_func",      32'(func),      32'd0);
        rst = 1'b0;
        step();

        send(16'h0123, 16'h0010);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_dst",   32'(dst_addr),  32'd1);
        chk("add_p1",    32'(p1_addr),   32'd2);
        chk("add_p0",    32'(p0_addr),   32'd3);
        chk("add_we",    32'(we),        32'd1);
        chk("add_npc",   32'(new_pc),    32'h0011);
        chk("add_redir", 32'(redirect),  32'd0);

        flag_z = 1'b1;
        send(16'hC3FE, 16'h0020);
        chk("br_t_redir", 32'(redirect), 32'd1);
        chk("br_t_npc",   32'(new_pc),   32'h001F);
        chk("br_t_we",    32'(we),       32'd0);
        step();
        chk("br_t_pulse", 32'(redirect), 32'd0);

        flag_z = 1'b0;
        send(16'hC3FE, 16'h0020);
        chk("br_nt_redir", 32'(redirect), 32'd0);
        chk("br_nt_npc",   32'(new_pc),   32'h0021);

        send(16'hB5A7, 16'h0040);
        chk("llb_re0",   32'(re0),     32'd0);
        chk("llb_re1",   32'(re1),     32'd0);
        chk("llb_shamt", 32'(shamt),   32'd0);
        chk("llb_func",  32'(func),    32'd4);
        chk("llb_src1",  32'(src1sel), 32'd0);

        send(16'h1234, 16'h0041);
        chk("addz_we", 32'(we), 32'd0);
        flag_z = 1'b1;
        send(16'h1234, 16'h0042);
        chk("addz_we_z", 32'(we), 32'd1);
        flag_z = 1'b0;

        send(16'hCE00, 16'hFFFF);
        chk("wrap_npc",   32'(new_pc),   32'h0000);
        chk("wrap_redir", 32'(redirect), 32'd1);
        step();

        // backpressure
        out_ready = 1'b0;
        send(16'h0456, 16'h0030);
        in_valid = 1'b1; instr = 16'h2789; pc = 16'h0031;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_dst",      32'(dst_addr), 32'd4);
            chk("bp_npc",      32'(new_pc),   32'h0031);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp2_dst",  32'(dst_addr), 32'd7);
        chk("bp2_func", 32'(func),     32'd1);
        chk("bp2_npc",  32'(new_pc),   32'h0032);
        step();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // halt
        send(16'hF000, 16'h0050);
        chk("hlt_set", 32'(hlt), 32'd1);
        chk("hlt_we",  32'(we),  32'd0);
        in_valid = 1'b1; instr = 16'h0123; pc = 16'h0051;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hlt_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        chk("hlt_sticky", 32'(hlt), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("hlt_clr", 32'(hlt), 32'd0);
        #1;
        chk("hlt_rdy", 32'(in_ready), 32'd1);
        step();

        // reset while held, with a simultaneous offer
        out_ready = 1'b0;
        send(16'h0456, 16'h0060);
        in_valid = 1'b1; instr = 16'h2789; pc = 16'h0061; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("rstbusy_valid", 32'(out_valid), 32'd0);
        chk("rstbusy_dst",   32'(dst_addr),  32'd0);
        step();

`ifdef ID_HAZARD_STALL_EN
        send(16'h0123, 16'h0070);
        in_valid = 1'b1; instr = 16'h2210; pc = 16'h0071;
        #1;
        chk("hz_stall1", 32'(in_ready), 32'd0);
        step();
        #1;
        chk("hz_stall2", 32'(in_ready), 32'd0);
        step();
        #1;
        chk("hz_free", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        send(16'h0023, 16'h0072);
        in_valid = 1'b1; instr = 16'h2300; pc = 16'h0073;
        #1;
        chk("hz_r0", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step();
`endif

        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered, parametrised instruction-decode pipeline stage between fetch and execute.
- Decodes the 16-bit-class ISA (ADD, ADDZ, SUB, AND, NOR, SLL, SRL, SRA, LHB, LLB, B, JAL, JR, HLT) into register-file and ALU controls.
- Resolves conditional branches from the N/Z/V flags and latches halt.
- Uses a valid/ready handshake on both sides so fetch and execute can stall independently.

Parameters:
- DATA_W, 16, instruction and PC width
- RA_W, 4, register address width (also shamt width)
- BOFF_W, 9, branch offset width; the offset is sign-extended to DATA_W

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents instr/pc
- in_ready  out  1  stage can accept
- instr  in  DATA_W  instruction word
- pc  in  DATA_W  PC of instr
- flag_n, flag_z, flag_v  in  1 each  current condition flags
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- p0_addr, p1_addr, dst_addr  out  RA_W each  register addresses
- re0, re1, we  out  1 each  read/write enables
- shamt  out  RA_W  shift amount
- func  out  3  ALU function
- src1sel  out  1  0 = immediate path (LLB/LHB)
- redirect  out  1  one-cycle pulse: taken branch
- new_pc  out  DATA_W  redirect target
- hlt  out  1  sticky halt

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-high.
- Reset values: out_valid=0, redirect=0, hlt=0, new_pc=0, all decoded fields 0, we=0.
- Accept rule: accept = in_valid && in_ready. in_ready = !hlt && (!out_valid || out_ready).
- Latency: exactly 1 cycle. On accept, all outputs register on the same edge and out_valid=1.
- Hold: if out_valid && !out_ready, every output holds and no new accept occurs.
- Drain: if out_ready and no accept, out_valid drops to 0.
- Opcode map (instr[15:12]): 0 ADD, 1 ADDZ, 2 SUB, 3 AND, 4 NOR, 5 SLL, 6 SRL, 7 SRA, A LHB, B LLB, C B, D JAL, E JR, F HLT.
- func: ADD/ADDZ=000, SUB=001, AND=010, NOR=011, SLL/LLB=100, SRL=101, LHB=110, SRA=111. Undefined opcodes give 000.
- Address fields:
  - dst_addr = instr[11:8]; p1_addr = instr[7:4].
  - p0_addr = instr[11:8] for LHB, else instr[3:0].
  - shamt = 0 for LLB, else instr[3:0].
- Enables:
  - re0 = re1 = 0 for LLB and B, else 1. src1sel = 0 for LLB/LHB.
  - we = 0 for B, HLT, JR and undefined opcodes. For ADDZ, we = flag_z sampled at accept. Otherwise we = 1.
- Branch conditions: cond = instr[11:9].
  - 000: !Z
  - 001: Z
  - 010: !Z && !N
  - 011: N
  - 100: !N
  - 101: N || Z
  - 110: V
  - 111: always
- Branch result: taken gives new_pc = pc + 1 + sext(instr[8:0]), with modulo 2^DATA_W wrap, and redirect=1 for exactly the first cycle out_valid is high for that bundle. Not taken gives redirect=0 and new_pc = pc + 1.
- Non-branch: new_pc = pc + 1, redirect=0.
- Same-cycle redirect: fetch handles the redirect pulse. If in_valid is presented in the same cycle redirect is high, that instruction is still accepted; squashing is fetch's responsibility.
- HLT: on accept, the bundle is emitted with we=0 and hlt is set to 1 and held until rst. in_ready is then 0 permanently.
- Reset while busy: rst while out_valid && !out_ready discards the bundle and restores the reset values next edge. rst overrides a simultaneous accept.

Optional Feature:
- Macro: ID_HAZARD_STALL_EN.
- Defined:
  - The stage keeps the dst_addr/we of the last two emitted bundles.
  - If a candidate instruction reads (re0/re1) a register matching either entry with we=1, in_ready is forced to 0 until that entry ages out.
  - An entry ages out on each out_valid && out_ready handshake; bubble cycles also age entries.
  - Register 0 never matches.
- Not defined: no hazard tracking; in_ready follows the base rule only.

Test Plan:
- ADD: rst high 2 cycles, then instr=0x0123, pc=0x0010, out_ready=1 -> next cycle out_valid=1, func=000, dst=1, p1=2, p0=3, we=1, new_pc=0x0011, redirect=0.
- Branch: instr=0xC3FE (cond 001, offset -2), Z=1, pc=0x0020 -> redirect pulse 1 cycle, new_pc=0x001F, we=0. Same with Z=0 -> redirect=0, new_pc=0x0021.
- Backpressure: out_ready=0 for 3 cycles after an accept -> outputs stable, in_ready=0. Second instruction emitted the cycle after out_ready=1, none lost or duplicated.
- HLT: instr=0xF000 -> hlt=1 and stays 1. Subsequent in_valid is never accepted (in_ready=0) until rst, after which hlt=0.
- Corner cases:
  - LLB instr=0xB5A7 -> re0=re1=0, shamt=0, func=100, src1sel=0.
  - ADDZ with Z=0 -> we=0.
  - pc=0xFFFF with B always, offset 0 -> new_pc=0x0000.
- With ID_HAZARD_STALL_EN: ADD r1 then SUB reading r1 back-to-back -> in_ready low 2 cycles with out_ready=1. Reading r0 -> no stall.
